// File: rtl/i3c_pkg.sv
// Shared constants and memory-port structs for the I3C DAT/DCT RAMs.
package i3c_pkg;

   // Address width for a RAM of the given depth, never narrower than one bit.
   function automatic int unsigned ram_aw(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int unsigned DAT_DEPTH = 128;
   localparam int unsigned DCT_DEPTH = 128;
   localparam int unsigned DatAw     = ram_aw(DAT_DEPTH);
   localparam int unsigned DctAw     = ram_aw(DCT_DEPTH);

   typedef struct packed {
      logic             req;
      logic             write;
      logic [DatAw-1:0] addr;
      logic [63:0]      wdata;
      logic [63:0]      wmask;
   } dat_mem_sink_t;

   typedef struct packed {
      logic [63:0] rdata;
      logic        rvalid;
      logic [1:0]  rerror;
   } dat_mem_src_t;

   typedef struct packed {
      logic             req;
      logic             write;
      logic [DctAw-1:0] addr;
      logic [127:0]     wdata;
      logic [127:0]     wmask;
   } dct_mem_sink_t;

   typedef struct packed {
      logic [127:0] rdata;
      logic         rvalid;
      logic [1:0]   rerror;
   } dct_mem_src_t;

endpackage

// File: rtl/i3c_ram_parity.sv
// Combinational even-parity generator, one bit per DataBitsPerMask-wide group.
// Only compiled when I3C_RAM_PARITY_EN is defined.
`ifdef I3C_RAM_PARITY_EN
module i3c_ram_parity #(
   parameter int unsigned Width           = 64,
   parameter int unsigned DataBitsPerMask = 32,
   localparam int unsigned Groups         = (Width + DataBitsPerMask - 1) / DataBitsPerMask
) (
   input  logic [Width-1:0]  data_i,
   output logic [Groups-1:0] parity_o
);

   always_comb begin
      parity_o = '0;
      for (int unsigned g = 0; g < Groups; g++) begin
         parity_o[g] = ^data_i[g*DataBitsPerMask +: DataBitsPerMask];
      end
   end

endmodule
`endif

// File: rtl/i3c_dxt_ram.sv
// Single-port RAM for the I3C DAT/DCT: bit-masked writes, 1-cycle reads.
// Optional per-group even parity is enabled with I3C_RAM_PARITY_EN.
module i3c_dxt_ram
   import i3c_pkg::*;
#(
   parameter int unsigned Depth           = 128,
   parameter int unsigned Width           = 64,
   parameter int unsigned DataBitsPerMask = 32,
   localparam int unsigned Aw             = ram_aw(Depth)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_i,
   input  logic             write_i,
   input  logic [Aw-1:0]    addr_i,
   input  logic [Width-1:0] wdata_i,
   input  logic [Width-1:0] wmask_i,
   output logic [Width-1:0] rdata_o,
   output logic             rvalid_o,
   output logic [1:0]       rerror_o,
   input  logic [7:0]       cfg_i
);

   if (Width % DataBitsPerMask != 0) begin : gen_width_check
      $fatal(1, "i3c_dxt_ram: Width must be a multiple of DataBitsPerMask");
   end

   logic [Width-1:0] mem [Depth];
   logic [Width-1:0] rdata_q;
   logic             rvalid_q;
   logic [1:0]       rerror_q;
   logic             addr_ok;
   logic             rd_en;
   logic             wr_en;
   logic [Width-1:0] rd_word;
   logic [Width-1:0] merged;
   logic             unused_cfg;

   assign unused_cfg = ^cfg_i;
   assign addr_ok    = (32'(addr_i) < Depth);
   assign rd_en      = req_i & ~write_i;
   assign wr_en      = req_i & write_i & addr_ok;

   // Combinational read serves both the read port and the masked-write merge.
   assign rd_word = addr_ok ? mem[addr_i] : '0;
   assign merged  = (rd_word & ~wmask_i) | (wdata_i & wmask_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= rd_en;
         if (rd_en) begin
            rdata_q <= rd_word;
         end
         if (wr_en) begin
            mem[addr_i] <= merged;
         end
      end
   end

`ifdef I3C_RAM_PARITY_EN
   localparam int unsigned Groups = Width / DataBitsPerMask;

   logic [Groups-1:0] par_mem [Depth];
   logic [Groups-1:0] wr_par;
   logic [Groups-1:0] rd_par;
   logic [Groups-1:0] grp_touch;
   logic [Groups-1:0] stored_par;

   i3c_ram_parity #(
      .Width           (Width),
      .DataBitsPerMask (DataBitsPerMask)
   ) u_par_wr (
      .data_i   (merged),
      .parity_o (wr_par)
   );

   i3c_ram_parity #(
      .Width           (Width),
      .DataBitsPerMask (DataBitsPerMask)
   ) u_par_rd (
      .data_i   (rd_word),
      .parity_o (rd_par)
   );

   // Untouched groups keep their old parity so a latent flip stays detectable.
   always_comb begin
      grp_touch = '0;
      for (int unsigned g = 0; g < Groups; g++) begin
         grp_touch[g] = |wmask_i[g*DataBitsPerMask +: DataBitsPerMask];
      end
   end

   assign stored_par = addr_ok ? par_mem[addr_i] : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rerror_q <= 2'b00;
      end else begin
         rerror_q <= {1'b0, rd_en & addr_ok & (rd_par != stored_par)};
         if (wr_en) begin
            for (int unsigned g = 0; g < Groups; g++) begin
               if (grp_touch[g]) begin
                  par_mem[addr_i][g] <= wr_par[g];
               end
            end
         end
      end
   end
`else
   assign rerror_q = 2'b00;
`endif

   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign rerror_o = rerror_q;

endmodule

// File: tb/tb_i3c_dxt_ram.sv
// Self-checking bench for i3c_dxt_ram: vector table, randomized model check, corner sequences.
module tb_i3c_dxt_ram;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DAT-shaped instance (Depth 128, Width 64)
   logic         req_a, write_a;
   logic [6:0]   addr_a;
   logic [63:0]  wdata_a, wmask_a, rdata_a;
   logic         rvalid_a;
   logic [1:0]   rerror_a;

   // Non-power-of-two depth instance
   logic         req_b, write_b;
   logic [6:0]   addr_b;
   logic [63:0]  wdata_b, wmask_b, rdata_b;
   logic         rvalid_b;
   logic [1:0]   rerror_b;

   // DCT-shaped instance (Width 128)
   logic         req_c, write_c;
   logic [6:0]   addr_c;
   logic [127:0] wdata_c, wmask_c, rdata_c;
   logic         rvalid_c;
   logic [1:0]   rerror_c;

   i3c_dxt_ram #(.Depth(128), .Width(64), .DataBitsPerMask(32)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req_a), .write_i(write_a), .addr_i(addr_a),
      .wdata_i(wdata_a), .wmask_i(wmask_a), .rdata_o(rdata_a), .rvalid_o(rvalid_a),
      .rerror_o(rerror_a), .cfg_i(8'h00)
   );

   i3c_dxt_ram #(.Depth(100), .Width(64), .DataBitsPerMask(32)) dut_b (
      .clk_i(clk), .rst_i(rst), .req_i(req_b), .write_i(write_b), .addr_i(addr_b),
      .wdata_i(wdata_b), .wmask_i(wmask_b), .rdata_o(rdata_b), .rvalid_o(rvalid_b),
      .rerror_o(rerror_b), .cfg_i(8'hA5)
   );

   i3c_dxt_ram #(.Depth(128), .Width(128), .DataBitsPerMask(32)) dut_c (
      .clk_i(clk), .rst_i(rst), .req_i(req_c), .write_i(write_c), .addr_i(addr_c),
      .wdata_i(wdata_c), .wmask_i(wmask_c), .rdata_o(rdata_c), .rvalid_o(rvalid_c),
      .rerror_o(rerror_c), .cfg_i(8'h3C)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [63:0] model [128];

   typedef struct {
      logic        req;
      logic        wr;
      logic [6:0]  addr;
      logic [63:0] wdata;
      logic [63:0] wmask;
      logic [63:0] exp_rdata;
      logic        exp_rvalid;
   } vec_t;

   vec_t vecs [9];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle on instance A and keep the word-level model in step.
   task automatic step_a(input logic req, input logic wr, input logic [6:0] addr,
                         input logic [63:0] wd, input logic [63:0] wm);
      req_a = req; write_a = wr; addr_a = addr; wdata_a = wd; wmask_a = wm;
      cyc();
      if (req && wr) model[addr] = (model[addr] & ~wm) | (wd & wm);
      req_a = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [63:0]  hold;
      logic [63:0]  exp_d;
      logic         exp_v;
      logic         r, w;
      logic [6:0]   a;
      logic [63:0]  d, m;
      logic [63:0]  x99;
      logic [127:0] dct;

      rst = 1'b1;
      req_a = 0; write_a = 0; addr_a = 0; wdata_a = 0; wmask_a = 0;
      req_b = 0; write_b = 0; addr_b = 0; wdata_b = 0; wmask_b = 0;
      req_c = 0; write_c = 0; addr_c = 0; wdata_c = 0; wmask_c = 0;
      repeat (2) cyc();
      check("reset_rdata", rdata_a, 0);
      check("reset_rvalid", rvalid_a, 0);
      check("reset_rerror", rerror_a, 0);
      rst = 1'b0;

      for (int i = 0; i < 128; i++) begin
         step_a(1, 1, 7'(i), (i == 5) ? 64'h1234 : {$urandom, $urandom}, '1);
      end

      // Requests under reset must be dropped.
      rst = 1'b1;
      req_a = 1; write_a = 1; addr_a = 7'd5; wdata_a = '1; wmask_a = '1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("rst_hold_rdata", rdata_a, 0);
         check("rst_hold_rvalid", rvalid_a, 0);
      end
      rst = 1'b0;
      req_a = 0;
      step_a(1, 0, 7'd5, 0, 0);
      check("rst_no_write_rdata", rdata_a, 64'h1234);
      check("rst_no_write_rvalid", rvalid_a, 1);

      vecs[0] = '{1, 1, 7'd3,   64'hFFFF_FFFF_FFFF_FFFF, '1, 64'h1234, 0};
      vecs[1] = '{1, 1, 7'd3,   64'h0, 64'h0000_0000_FFFF_FFFF, 64'h1234, 0};
      vecs[2] = '{1, 0, 7'd3,   64'h0, 64'h0, 64'hFFFF_FFFF_0000_0000, 1};
      vecs[3] = '{1, 1, 7'd0,   64'hA5, '1, 64'hFFFF_FFFF_0000_0000, 0};
      vecs[4] = '{1, 1, 7'd127, 64'h5A, '1, 64'hFFFF_FFFF_0000_0000, 0};
      vecs[5] = '{1, 0, 7'd0,   64'h0, 64'h0, 64'hA5, 1};
      vecs[6] = '{1, 0, 7'd127, 64'h0, 64'h0, 64'h5A, 1};
      vecs[7] = '{1, 0, 7'd0,   64'h0, 64'h0, 64'hA5, 1};
      vecs[8] = '{0, 0, 7'd0,   64'h0, 64'h0, 64'hA5, 0};
      for (int i = 0; i < 9; i++) begin
         step_a(vecs[i].req, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
         check($sformatf("vec%0d_rdata", i), rdata_a, vecs[i].exp_rdata);
         check($sformatf("vec%0d_rvalid", i), rvalid_a, vecs[i].exp_rvalid);
         check($sformatf("vec%0d_rerror", i), rerror_a, 0);
      end

      hold = 64'hA5;
      for (int i = 0; i < 500; i++) begin
         r = ($urandom_range(0, 3) != 0);
         w = $urandom_range(0, 1) == 1;
         a = 7'($urandom_range(0, 127));
         d = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0: m = '1;
            1: m = 64'h0000_0000_FFFF_FFFF;
            2: m = 64'hFFFF_FFFF_0000_0000;
            default: m = {$urandom, $urandom};
         endcase
         exp_v = r && !w;
         if (exp_v) hold = model[a];
         exp_d = hold;
         step_a(r, w, a, d, m);
         check($sformatf("rand%0d_rdata", i), rdata_a, exp_d);
         check($sformatf("rand%0d_rvalid", i), rvalid_a, exp_v);
         check($sformatf("rand%0d_rerror", i), rerror_a, 0);
      end

      // Out-of-range accesses on the depth-100 instance.
      x99 = 64'hDEAD_BEEF_0BAD_F00D;
      req_b = 1; write_b = 1; addr_b = 7'd99; wdata_b = x99; wmask_b = '1;
      cyc();
      addr_b = 7'd120; wdata_b = '1;
      cyc();
      check("oor_write_rvalid", rvalid_b, 0);
      write_b = 0;
      cyc();
      check("oor_read_rdata", rdata_b, 0);
      check("oor_read_rvalid", rvalid_b, 1);
      check("oor_read_rerror", rerror_b, 0);
      addr_b = 7'd99;
      cyc();
      check("addr99_rdata", rdata_b, x99);
      check("addr99_rvalid", rvalid_b, 1);
      req_b = 0;

      // Full-width DCT round trip, then idle hold.
      dct = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
      req_c = 1; write_c = 1; addr_c = 7'd9; wdata_c = dct; wmask_c = '1;
      cyc();
      write_c = 0;
      cyc();
      check("dct_rdata", rdata_c, dct);
      check("dct_rvalid", rvalid_c, 1);
      req_c = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         check("dct_idle_rdata", rdata_c, dct);
         check("dct_idle_rvalid", rvalid_c, 0);
      end

`ifdef I3C_RAM_PARITY_EN
      step_a(1, 1, 7'd7, 64'h0F0F_1234_5678_9ABC, '1);
      dut.mem[7][0] = ~dut.mem[7][0];
      step_a(1, 0, 7'd7, 0, 0);
      check("parity_rdata", rdata_a, model[7] ^ 64'h1);
      check("parity_rvalid", rvalid_a, 1);
      check("parity_rerror", rerror_a, 2'b01);
`else
      step_a(1, 0, 7'd7, 0, 0);
      check("noparity_rdata", rdata_a, model[7]);
      check("noparity_rerror", rerror_a, 2'b00);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
